rot_pick_scheduler: RTL and testbench

Time-multiplexes the single shared rotation engine (TrigLUT sin/cos lookup plus center + r·trig arithmetic) among up to N_REQ rotating objects. Once per frame it snapshots every requester's angle, center, radius and phase, issues each enabled requester to the engine in ascending index order, and waits out the LUT latency. It then latches the rotated coordinates into per-requester output registers read by the sprite/draw logic. It sits between the frame-timing logic (vsync-derived pulse) and the rotation engine.

---
 rtl/rot_sched_pkg.sv | 26 ++
 rtl/rot_first_set.sv | 23 ++
 rtl/rot_pick_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_rot_pick_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_sched_pkg.sv
// Shared types and constants for the rotation-engine scheduler.
package rot_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  localparam int unsigned ANGLE_W       = 9;
  localparam int unsigned COORD_W       = 10;
  localparam int unsigned ANGLE_QUARTER = 112;
  localparam int unsigned ANGLE_FULL    = 448;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_CW   = 2'd1;
  localparam logic [1:0] PH_CCW  = 2'd2;

  // Phase code 3 is undefined for the engine and is treated as no shift.
  function automatic logic [1:0] norm_phase(input logic [1:0] ph);
    return (ph == 2'd3) ? PH_NONE : ph;
  endfunction

endpackage

// File: rtl/rot_first_set.sv
// Lowest-set-bit priority encoder used to pick the next pending requester.
module rot_first_set #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        idx = IDX_W'(i - 1);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rot_pick_scheduler.sv
// Time-multiplexes the shared rotation engine among N_REQ requesters, one
// pass per frame_start, latching each engine result into per-requester regs.
module rot_pick_scheduler
  import rot_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LUT_LAT = 2,
  parameter int unsigned ANGLE_W = rot_sched_pkg::ANGLE_W,
  parameter int unsigned COORD_W = rot_sched_pkg::COORD_W
) (
  input  logic                       CLK,
  input  logic                       Reset_n,
  input  logic                       frame_start,
  input  logic [N_REQ-1:0]           req_en,
  input  logic [N_REQ*ANGLE_W-1:0]   req_angle,
  input  logic [N_REQ*2-1:0]         req_phase,
  input  logic [N_REQ*COORD_W-1:0]   req_cx,
  input  logic [N_REQ*COORD_W-1:0]   req_cy,
  input  logic [N_REQ*COORD_W-1:0]   req_radius,
  output logic [ANGLE_W-1:0]         eng_angle,
  output logic [1:0]                 eng_phase,
  output logic [COORD_W-1:0]         eng_cx,
  output logic [COORD_W-1:0]         eng_cy,
  output logic [COORD_W-1:0]         eng_radius,
  input  logic [COORD_W-1:0]         eng_rotx,
  input  logic [COORD_W-1:0]         eng_roty,
  output logic [N_REQ*COORD_W-1:0]   rot_x,
  output logic [N_REQ*COORD_W-1:0]   rot_y,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LUT_LAT + 1);

  state_e                   state_q, state_d;
  logic [N_REQ-1:0]         pending_q, pending_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [N_REQ*ANGLE_W-1:0] snap_angle_q, snap_angle_d;
  logic [N_REQ*2-1:0]       snap_phase_q, snap_phase_d;
  logic [N_REQ*COORD_W-1:0] snap_cx_q, snap_cx_d;
  logic [N_REQ*COORD_W-1:0] snap_cy_q, snap_cy_d;
  logic [N_REQ*COORD_W-1:0] snap_radius_q, snap_radius_d;

  logic [ANGLE_W-1:0]       eng_angle_q, eng_angle_d;
  logic [1:0]               eng_phase_q, eng_phase_d;
  logic [COORD_W-1:0]       eng_cx_q, eng_cx_d;
  logic [COORD_W-1:0]       eng_cy_q, eng_cy_d;
  logic [COORD_W-1:0]       eng_radius_q, eng_radius_d;

  logic [N_REQ*COORD_W-1:0] rot_x_q, rot_x_d;
  logic [N_REQ*COORD_W-1:0] rot_y_q, rot_y_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q, overrun_d;

  logic [IDX_W-1:0]         first_idx;
  logic                     first_any;

  rot_first_set #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_first_set (
    .req (pending_q),
    .idx (first_idx),
    .any (first_any)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic for the scan/issue/wait/capture loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame_start) state_d = ST_SCAN;
      ST_SCAN:    state_d = first_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SCAN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode and register-backed outputs.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = frame_done_q;
    overrun    = overrun_q;
    eng_angle  = eng_angle_q;
    eng_phase  = eng_phase_q;
    eng_cx     = eng_cx_q;
    eng_cy     = eng_cy_q;
    eng_radius = eng_radius_q;
    rot_x      = rot_x_q;
    rot_y      = rot_y_q;
  end

  // Datapath next values: snapshot, selection, engine drive, capture.
  always_comb begin
    pending_d     = pending_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    snap_angle_d  = snap_angle_q;
    snap_phase_d  = snap_phase_q;
    snap_cx_d     = snap_cx_q;
    snap_cy_d     = snap_cy_q;
    snap_radius_d = snap_radius_q;
    eng_angle_d   = eng_angle_q;
    eng_phase_d   = eng_phase_q;
    eng_cx_d      = eng_cx_q;
    eng_cy_d      = eng_cy_q;
    eng_radius_d  = eng_radius_q;
    rot_x_d       = rot_x_q;
    rot_y_d       = rot_y_q;
    frame_done_d  = 1'b0;
    overrun_d     = frame_start && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          pending_d     = req_en;
          snap_angle_d  = req_angle;
          snap_phase_d  = req_phase;
          snap_cx_d     = req_cx;
          snap_cy_d     = req_cy;
          snap_radius_d = req_radius;
        end
      end
      ST_SCAN: begin
        if (first_any) begin
          idx_d        = first_idx;
          // Engine regs load on the SCAN->ISSUE edge so the engine sees the
          // selected requester throughout the ISSUE cycle.
          eng_angle_d  = snap_angle_q[first_idx*ANGLE_W +: ANGLE_W];
          eng_phase_d  = norm_phase(snap_phase_q[first_idx*2 +: 2]);
          eng_cx_d     = snap_cx_q[first_idx*COORD_W +: COORD_W];
          eng_cy_d     = snap_cy_q[first_idx*COORD_W +: COORD_W];
          eng_radius_d = snap_radius_q[first_idx*COORD_W +: COORD_W];
        end else begin
          frame_done_d = 1'b1;
        end
      end
      ST_ISSUE: cnt_d = CNT_W'(LUT_LAT);
      ST_WAIT:  cnt_d = cnt_q - CNT_W'(1);
      ST_CAPTURE: begin
        rot_x_d[idx_q*COORD_W +: COORD_W] = eng_rotx;
        rot_y_d[idx_q*COORD_W +: COORD_W] = eng_roty;
        pending_d[idx_q]                  = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      pending_q     <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      snap_angle_q  <= '0;
      snap_phase_q  <= '0;
      snap_cx_q     <= '0;
      snap_cy_q     <= '0;
      snap_radius_q <= '0;
      eng_angle_q   <= '0;
      eng_phase_q   <= '0;
      eng_cx_q      <= '0;
      eng_cy_q      <= '0;
      eng_radius_q  <= '0;
      rot_x_q       <= '0;
      rot_y_q       <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      snap_angle_q  <= snap_angle_d;
      snap_phase_q  <= snap_phase_d;
      snap_cx_q     <= snap_cx_d;
      snap_cy_q     <= snap_cy_d;
      snap_radius_q <= snap_radius_d;
      eng_angle_q   <= eng_angle_d;
      eng_phase_q   <= eng_phase_d;
      eng_cx_q      <= eng_cx_d;
      eng_cy_q      <= eng_cy_d;
      eng_radius_q  <= eng_radius_d;
      rot_x_q       <= rot_x_d;
      rot_y_q       <= rot_y_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_rot_pick_scheduler.sv
// Self-checking bench for rot_pick_scheduler: engine model with LUT latency,
// schedule-based reference model, per-cycle compare plus literal checks.
module tb_rot_pick_scheduler;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int AW = 9;
  localparam int CW = 10;
  localparam int P  = L + 3;

  logic              CLK;
  logic              Reset_n;
  logic              frame_start;
  logic [N-1:0]      req_en;
  logic [N*AW-1:0]   req_angle;
  logic [N*2-1:0]    req_phase;
  logic [N*CW-1:0]   req_cx, req_cy, req_radius;
  logic [AW-1:0]     eng_angle;
  logic [1:0]        eng_phase;
  logic [CW-1:0]     eng_cx, eng_cy, eng_radius;
  logic [CW-1:0]     eng_rotx, eng_roty;
  logic [N*CW-1:0]   rot_x, rot_y;
  logic              busy, frame_done, overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  rot_pick_scheduler #(
    .N_REQ   (N),
    .LUT_LAT (L),
    .ANGLE_W (AW),
    .COORD_W (CW)
  ) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .req_en      (req_en),
    .req_angle   (req_angle),
    .req_phase   (req_phase),
    .req_cx      (req_cx),
    .req_cy      (req_cy),
    .req_radius  (req_radius),
    .eng_angle   (eng_angle),
    .eng_phase   (eng_phase),
    .eng_cx      (eng_cx),
    .eng_cy      (eng_cy),
    .eng_radius  (eng_radius),
    .eng_rotx    (eng_rotx),
    .eng_roty    (eng_roty),
    .rot_x       (rot_x),
    .rot_y       (rot_y),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Coarse rotation: quadrant offset of r plus a residual term; phase code 3
  // is given a distinct meaning so an un-normalised phase shows up.
  function automatic logic [2*CW-1:0] eng_f(input int a, input int ph, input int cx,
                                            input int cy, input int r);
    int eff, q, rem, xi, yi;
    eff = a;
    if (ph == 1) eff += 112;
    else if (ph == 2) eff += 448 - 112;
    else if (ph == 3) eff += 224;
    eff = eff % 448;
    q   = eff / 112;
    rem = eff % 112;
    xi  = cx + rem;
    yi  = cy + 2 * rem;
    case (q)
      0: xi += r;
      1: yi += r;
      2: xi -= r;
      default: yi -= r;
    endcase
    return {CW'(xi), CW'(yi)};
  endfunction

  // External engine: result follows its inputs after L registered stages.
  logic [2*CW-1:0] eng_now, pipe1, pipe2;
  always_comb eng_now = eng_f(int'(eng_angle), int'(eng_phase), int'(eng_cx),
                              int'(eng_cy), int'(eng_radius));
  always @(posedge CLK) begin
    pipe1 <= eng_now;
    pipe2 <= pipe1;
  end
  assign eng_rotx = pipe2[2*CW-1:CW];
  assign eng_roty = pipe2[CW-1:0];

  // Reference model: a pass is a timetable derived from its start cycle.
  int s_a[N], s_p[N], s_cx[N], s_cy[N], s_r[N];
  int m_list[N];
  int m_k = 0, m_t = 0, m_end = 0;
  bit m_active = 0;
  int exp_rx[N], exp_ry[N];
  int exp_ea = 0, exp_ep = 0, exp_ecx = 0, exp_ecy = 0, exp_er = 0;
  bit exp_busy = 0, exp_fd = 0, exp_ov = 0;

  always @(posedge CLK) begin
    int c, n, id, ph;
    bit busy_c;
    logic [2*CW-1:0] res;
    c = cyc;
    if (!Reset_n) begin
      m_active = 0;
      exp_busy = 0; exp_fd = 0; exp_ov = 0;
      exp_ea = 0; exp_ep = 0; exp_ecx = 0; exp_ecy = 0; exp_er = 0;
      for (int i = 0; i < N; i++) begin exp_rx[i] = 0; exp_ry[i] = 0; end
      chk_en = 1;
    end else begin
      busy_c = m_active && (c >= m_t + 1) && (c <= m_end);
      exp_ov = frame_start && busy_c;
      if (frame_start && !busy_c) begin
        m_k = 0;
        for (int i = 0; i < N; i++) begin
          s_a[i]  = int'(req_angle[i*AW +: AW]);
          s_p[i]  = int'(req_phase[i*2 +: 2]);
          s_cx[i] = int'(req_cx[i*CW +: CW]);
          s_cy[i] = int'(req_cy[i*CW +: CW]);
          s_r[i]  = int'(req_radius[i*CW +: CW]);
          if (req_en[i]) begin m_list[m_k] = i; m_k++; end
        end
        m_t = c;
        m_end = c + 1 + m_k * P;
        m_active = 1;
      end
      n = c + 1;
      exp_busy = m_active && (n >= m_t + 1) && (n <= m_end);
      exp_fd   = m_active && (n == m_end + 1);
      for (int j = 0; j < m_k; j++) begin
        id = m_list[j];
        ph = (s_p[id] == 3) ? 0 : s_p[id];
        if (m_active && n == m_t + 2 + j * P) begin
          exp_ea = s_a[id]; exp_ep = ph; exp_ecx = s_cx[id];
          exp_ecy = s_cy[id]; exp_er = s_r[id];
        end
        if (m_active && n == m_t + 4 + L + j * P) begin
          res = eng_f(s_a[id], ph, s_cx[id], s_cy[id], s_r[id]);
          exp_rx[id] = int'(res[2*CW-1:CW]);
          exp_ry[id] = int'(res[CW-1:0]);
        end
      end
    end
    cyc = c + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      chk("overrun", int'(overrun), int'(exp_ov));
      chk("eng_angle", int'(eng_angle), exp_ea);
      chk("eng_phase", int'(eng_phase), exp_ep);
      chk("eng_cx", int'(eng_cx), exp_ecx);
      chk("eng_cy", int'(eng_cy), exp_ecy);
      chk("eng_radius", int'(eng_radius), exp_er);
      for (int i = 0; i < N; i++) begin
        chk("rot_x", int'(rot_x[i*CW +: CW]), exp_rx[i]);
        chk("rot_y", int'(rot_y[i*CW +: CW]), exp_ry[i]);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic set_req(input int i, input int a, input int ph, input int cx,
                         input int cy, input int r);
    req_angle[i*AW +: AW]  = AW'(a);
    req_phase[i*2 +: 2]    = 2'(ph);
    req_cx[i*CW +: CW]     = CW'(cx);
    req_cy[i*CW +: CW]     = CW'(cy);
    req_radius[i*CW +: CW] = CW'(r);
  endtask

  function automatic int rx(input int i);
    return int'(rot_x[i*CW +: CW]);
  endfunction
  function automatic int ry(input int i);
    return int'(rot_y[i*CW +: CW]);
  endfunction

  initial begin
    int t, bcnt;
    Reset_n = 1'b0; frame_start = 1'b0; req_en = '0;
    req_angle = '0; req_phase = '0; req_cx = '0; req_cy = '0; req_radius = '0;
    repeat (3) tick();
    chk("lit_reset_busy", int'(busy), 0);
    chk("lit_reset_rotx", int'(rot_x[0 +: 32]), 0);
    chk("lit_reset_eng", int'(eng_angle), 0);
    chk("lit_reset_pulses", int'({frame_done, overrun}), 0);
    Reset_n = 1'b1;
    tick();

    // Single requester, angle 0.
    set_req(0, 0, 0, 100, 200, 50);
    req_en = 4'b0001; frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    wait_to(t + 6);
    chk("lit_one_rx0", rx(0), 150);
    chk("lit_one_ry0", ry(0), 200);
    chk("lit_one_fd_early", int'(frame_done), 0);
    wait_to(t + 7);
    chk("lit_one_fd", int'(frame_done), 1);

    // All four requesters, quadrant angles.
    set_req(1, 112, 0, 300, 100, 40);
    set_req(2, 224, 0, 400, 400, 30);
    set_req(3, 336, 0, 50, 60, 20);
    req_en = 4'b1111; frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    bcnt = 0;
    for (int i = 1; i <= 21; i++) begin
      if (busy) bcnt++;
      tick();
    end
    chk("lit_all_busy_cycles", bcnt, 21);
    chk("lit_all_fd", int'(frame_done), 1);
    chk("lit_all_rx1", rx(1), 300);
    chk("lit_all_ry1", ry(1), 140);
    chk("lit_all_rx2", rx(2), 370);
    chk("lit_all_ry3", ry(3), 40);

    // Sparse mask, started in the frame_done cycle of the previous pass.
    set_req(1, 5, 1, 310, 110, 41);
    set_req(3, 7, 2, 60, 70, 21);
    req_en = 4'b1010; frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    wait_to(t + 11);
    chk("lit_sparse_fd_early", int'(frame_done), 0);
    wait_to(t + 12);
    chk("lit_sparse_fd", int'(frame_done), 1);
    chk("lit_sparse_keep0", rx(0), 150);
    chk("lit_sparse_keep2", rx(2), 370);
    tick();

    // Empty mask.
    req_en = 4'b0000; frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    wait_to(t + 2);
    chk("lit_empty_fd", int'(frame_done), 1);
    tick();

    // Mid-pass input change and a frame_start while busy.
    set_req(0, 10, 3, 200, 100, 10);
    set_req(1, 120, 1, 210, 110, 12);
    set_req(2, 230, 2, 220, 120, 14);
    set_req(3, 300, 3, 230, 130, 16);
    req_en = 4'b1111; frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    wait_to(t + 3);
    for (int i = 0; i < N; i++) req_angle[i*AW +: AW] = AW'(50);
    req_en = 4'b0001;
    wait_to(t + 5);
    frame_start = 1'b1;
    tick(); frame_start = 1'b0;
    chk("lit_overrun", int'(overrun), 1);
    wait_to(t + 22);
    chk("lit_overrun_fd", int'(frame_done), 1);
    chk("lit_snap_rx0", rx(0), 220);
    chk("lit_snap_ry0", ry(0), 120);
    tick();

    // Reset while waiting on the engine, then a clean pass.
    set_req(0, 100, 0, 10, 20, 5);
    req_en = 4'b0001; frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    wait_to(t + 3);
    Reset_n = 1'b0;
    tick();
    chk("lit_rst_busy", int'(busy), 0);
    chk("lit_rst_rx0", rx(0), 0);
    chk("lit_rst_eng", int'(eng_angle), 0);
    Reset_n = 1'b1;
    tick();
    frame_start = 1'b1; t = cyc;
    tick(); frame_start = 1'b0;
    wait_to(t + 6);
    chk("lit_after_rst_rx0", rx(0), 115);
    chk("lit_after_rst_ry0", ry(0), 220);
    chk("lit_after_rst_rx1", rx(1), 0);
    wait_to(t + 7);
    chk("lit_after_rst_fd", int'(frame_done), 1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
